// File: rtl/multiply_accumulate_unit_pkg.sv
// ----------------------------------------------------------------------------
// multiply_accumulate_unit_pkg: opcodes, state encoding, iteration-count helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package multiply_accumulate_unit_pkg;

  localparam logic [3:0] OP_MUL   = 4'b0000;
  localparam logic [3:0] OP_MLA   = 4'b0001;
  localparam logic [3:0] OP_UMULL = 4'b0100;
  localparam logic [3:0] OP_UMLAL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_SMLAL = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int calc_iters(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  function automatic logic opcode_is_legal(input logic [3:0] op);
    return (op == OP_MUL)   || (op == OP_MLA)   ||
           (op == OP_UMULL) || (op == OP_UMLAL) ||
           (op == OP_SMULL) || (op == OP_SMLAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multiply_accumulate_unit_if.sv
// ----------------------------------------------------------------------------
// multiply_accumulate_unit_if: request/result bundle of the MAC unit
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface multiply_accumulate_unit_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   flush;
  logic [3:0]             opcode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       c;
  logic [WIDTH-1:0]       d;
  logic                   ready;
  logic                   done;
  logic [2*WIDTH-1:0]     result;
  logic                   n_flag;
  logic                   z_flag;
  logic                   illegal;

  modport master (
    output start, flush, opcode, a, b, c, d,
    input  ready, done, result, n_flag, z_flag, illegal
  );

  modport slave (
    input  start, flush, opcode, a, b, c, d,
    output ready, done, result, n_flag, z_flag, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multiply_accumulate_unit_conditional_negate.sv
// ----------------------------------------------------------------------------
// conditional_negate: two's-complement negation when en is high
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conditional_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);
  assign dout = en ? (~din + WIDTH'(1)) : din;
endmodule

`default_nettype wire

// File: rtl/multiply_accumulate_unit.sv
// ----------------------------------------------------------------------------
// multiply_accumulate_unit: iterative shift-add multiplier with accumulate
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multiply_accumulate_unit
  import multiply_accumulate_unit_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiply_accumulate_unit_if.slave bus
);
  localparam int N     = calc_iters(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      pend_q, pend_d;
  logic               neg_q, neg_d;
  logic               long_q, long_d;
  logic               illegal_op_q, illegal_op_d;
  logic [PW-1:0]      result_q, result_d;
  logic               n_q, n_d;
  logic               z_q, z_d;
  logic               illegal_q, illegal_d;

  logic               w_legal, w_signed_op, w_done, w_pend_n, w_pend_z;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [PW-1:0]      w_prod_fixed, w_partial, w_add_x, w_add_y, w_sum;

  assign w_legal     = opcode_is_legal(bus.opcode);
  assign w_signed_op = bus.opcode[2] & bus.opcode[1];

  conditional_negate #(.WIDTH(WIDTH)) u_neg_a (
    .din(bus.a), .en(w_signed_op & bus.a[WIDTH-1]), .dout(w_mag_a)
  );
  conditional_negate #(.WIDTH(WIDTH)) u_neg_b (
    .din(bus.b), .en(w_signed_op & bus.b[WIDTH-1]), .dout(w_mag_b)
  );
  conditional_negate #(.WIDTH(PW)) u_neg_prod (
    .din(prod_q), .en(neg_q), .dout(w_prod_fixed)
  );

  // Multiple of the multiplicand selected by the low multiplier digit.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) w_partial = w_partial + (mcand_q << j);
    end
  end

  // The one 2*WIDTH adder: partial-product accumulation in CALC,
  // sign-fixed product plus accumulator in ACC.
  assign w_add_x = (state_q == ST_ACC) ? w_prod_fixed : prod_q;
  assign w_add_y = (state_q == ST_ACC) ? acc_q : w_partial;
  assign w_sum   = w_add_x + w_add_y;

  assign w_pend_n = long_q ? pend_q[PW-1] : pend_q[WIDTH-1];
  assign w_pend_z = (pend_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    acc_d        = acc_q;
    pend_d       = pend_q;
    neg_d        = neg_q;
    long_d       = long_q;
    illegal_op_d = illegal_op_q;
    result_d     = result_q;
    n_d          = n_q;
    z_d          = z_q;
    illegal_d    = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          mcand_d      = {{WIDTH{1'b0}}, w_mag_a};
          mplier_d     = w_mag_b;
          prod_d       = '0;
          cnt_d        = '0;
          neg_d        = w_signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          long_d       = bus.opcode[2];
          acc_d        = '0;
          if (bus.opcode[0]) begin
            acc_d = bus.opcode[2] ? {bus.c, bus.d} : {{WIDTH{1'b0}}, bus.c};
          end
          illegal_op_d = !w_legal;
          pend_d       = result_q;
          state_d      = w_legal ? ST_CALC : ST_DONE;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          prod_d   = w_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          pend_d  = long_q ? w_sum : {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // A flush here discards the finished op without touching visible state.
        if (!bus.flush) begin
          result_d  = pend_q;
          illegal_d = illegal_op_q;
          if (!illegal_op_q) begin
            n_d = w_pend_n;
            z_d = w_pend_z;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      acc_q        <= '0;
      pend_q       <= '0;
      neg_q        <= 1'b0;
      long_q       <= 1'b0;
      illegal_op_q <= 1'b0;
      result_q     <= '0;
      n_q          <= 1'b0;
      z_q          <= 1'b1;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      neg_q        <= neg_d;
      long_q       <= long_d;
      illegal_op_q <= illegal_op_d;
      result_q     <= result_d;
      n_q          <= n_d;
      z_q          <= z_d;
      illegal_q    <= illegal_d;
    end
  end

  assign w_done      = (state_q == ST_DONE) && !bus.flush;
  assign bus.ready   = (state_q == ST_IDLE);
  assign bus.done    = w_done;
  assign bus.result  = w_done ? pend_q : result_q;
  assign bus.n_flag  = (w_done && !illegal_op_q) ? w_pend_n : n_q;
  assign bus.z_flag  = (w_done && !illegal_op_q) ? w_pend_z : z_q;
  assign bus.illegal = w_done ? illegal_op_q : illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_multiply_accumulate_unit.sv
// ----------------------------------------------------------------------------
// tb_multiply_accumulate_unit: directed vector table plus flush/reset sequences
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multiply_accumulate_unit;
  import multiply_accumulate_unit_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  multiply_accumulate_unit_if #(.WIDTH(WIDTH)) bus ();

  multiply_accumulate_unit #(.WIDTH(WIDTH), .BITS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 64'(bus.ready), 64'd1);
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    @(negedge clk);
    bus.opcode = op; bus.a = a; bus.b = b; bus.c = c; bus.d = d;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.opcode = 4'hF;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    bus.c = 32'hFFFF_0000; bus.d = 32'h0F0F_0F0F;
  endtask

  task automatic do_op(input vec_t v);
    int lat = 0;
    bit seen = 0;
    bit ready_seen = 0;
    logic [63:0] r;
    wait_ready();
    launch(v.op, v.a, v.b, v.c, v.d);
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.ready) ready_seen = 1;
      if (bus.done) seen = 1;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, bus.result, v.res);
    chk({v.name, " n_flag"}, 64'(bus.n_flag), 64'(v.n));
    chk({v.name, " z_flag"}, 64'(bus.z_flag), 64'(v.z));
    chk({v.name, " illegal"}, 64'(bus.illegal), 64'(v.ill));
    chk({v.name, " ready_low"}, 64'(ready_seen), 64'd0);
    r = bus.result;
    @(negedge clk);
    chk({v.name, " hold"}, bus.result, v.res);
    chk({v.name, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic expect_quiet(input string nm, input int cycles);
    bit seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    bit seen;
    vec_t v;

    vecs[0]  = '{"mul_7x6",      OP_MUL,   32'd7,        32'd6,        32'd0, 32'd0,  64'd42,                 1'b0, 1'b0, 1'b0, 34};
    vecs[1]  = '{"smull_m3x5",   OP_SMULL, 32'hFFFFFFFD, 32'd5,        32'd0, 32'd0,  64'hFFFFFFFF_FFFFFFF1,  1'b1, 1'b0, 1'b0, 34};
    vecs[2]  = '{"smlal_m3x5",   OP_SMLAL, 32'hFFFFFFFD, 32'd5,        32'd0, 32'd15, 64'd0,                  1'b0, 1'b1, 1'b0, 34};
    vecs[3]  = '{"umlal_max",    OP_UMLAL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1,  64'hFFFFFFFE_00000002,  1'b1, 1'b0, 1'b0, 34};
    vecs[4]  = '{"mla_wrap",     OP_MLA,   32'h80000000, 32'd2,        32'd5, 32'd0,  64'd5,                  1'b0, 1'b0, 1'b0, 34};
    vecs[5]  = '{"mla_max",      OP_MLA,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd9,  64'd3,                  1'b0, 1'b0, 1'b0, 34};
    vecs[6]  = '{"mul_neg",      OP_MUL,   32'h80000000, 32'd1,        32'd0, 32'd0,  64'h00000000_80000000,  1'b1, 1'b0, 1'b0, 34};
    vecs[7]  = '{"smull_minsq",  OP_SMULL, 32'h80000000, 32'h80000000, 32'd0, 32'd0,  64'h40000000_00000000,  1'b0, 1'b0, 1'b0, 34};
    vecs[8]  = '{"smull_maxm1",  OP_SMULL, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,  64'hFFFFFFFF_80000001,  1'b1, 1'b0, 1'b0, 34};
    vecs[9]  = '{"umull_zero",   OP_UMULL, 32'd0,        32'h00012345, 32'd0, 32'd0,  64'd0,                  1'b0, 1'b1, 1'b0, 34};
    vecs[10] = '{"illegal_f",    4'b1111,  32'd3,        32'd3,        32'd0, 32'd0,  64'd0,                  1'b0, 1'b1, 1'b1, 1};
    vecs[11] = '{"mul_7x6_b",    OP_MUL,   32'd7,        32'd6,        32'd0, 32'd0,  64'd42,                 1'b0, 1'b0, 1'b0, 34};
    vecs[12] = '{"illegal_2",    4'b0010,  32'd9,        32'd9,        32'd0, 32'd0,  64'd42,                 1'b0, 1'b0, 1'b1, 1};

    bus.start = 1'b0; bus.flush = 1'b0; bus.opcode = 4'h0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready",   64'(bus.ready),   64'd1);
    chk("rst done",    64'(bus.done),    64'd0);
    chk("rst illegal", 64'(bus.illegal), 64'd0);
    chk("rst result",  bus.result,       64'd0);
    chk("rst n_flag",  64'(bus.n_flag),  64'd0);
    chk("rst z_flag",  64'(bus.z_flag),  64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) do_op(vecs[i]);

    // Flush mid-CALC with a start pulse that must be ignored
    wait_ready();
    launch(OP_MUL, 32'd5, 32'd5, 32'd0, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      if (i == 4) begin bus.opcode = 4'b0010; bus.start = 1'b1; end
      if (i == 5) bus.start = 1'b0;
    end
    chk("flush busy ready", 64'(bus.ready), 64'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush ready", 64'(bus.ready), 64'd1);
    chk("flush result", bus.result, 64'd42);
    chk("flush no early done", 64'(seen), 64'd0);
    expect_quiet("flush no done", 40);

    v = '{"mul_3x3", OP_MUL, 32'd3, 32'd3, 32'd0, 32'd0, 64'd9, 1'b0, 1'b0, 1'b0, 34};
    do_op(v);

    // Flush arriving in the DONE cycle suppresses done and keeps the result
    wait_ready();
    launch(OP_MUL, 32'd2, 32'd2, 32'd0, 32'd0);
    seen = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("dflush no early done", 64'(seen), 64'd0);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("dflush done", 64'(bus.done), 64'd0);
    chk("dflush result", bus.result, 64'd9);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("dflush ready", 64'(bus.ready), 64'd1);
    chk("dflush kept", bus.result, 64'd9);
    expect_quiet("dflush no done", 5);

    // start together with flush in IDLE is dropped
    @(negedge clk);
    bus.opcode = OP_MUL; bus.a = 32'd4; bus.b = 32'd4;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("startflush ready", 64'(bus.ready), 64'd1);
    expect_quiet("startflush no done", 40);
    chk("startflush result", bus.result, 64'd9);

    // Reset mid-CALC
    launch(OP_MUL, 32'd7, 32'd6, 32'd0, 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst ready",  64'(bus.ready),  64'd1);
    chk("midrst done",   64'(bus.done),   64'd0);
    chk("midrst result", bus.result,      64'd0);
    chk("midrst z_flag", 64'(bus.z_flag), 64'd1);
    chk("midrst n_flag", 64'(bus.n_flag), 64'd0);
    rst_n = 1'b1;
    expect_quiet("midrst no done", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
